// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage IEEE-754 single-precision rounding and packing unit.
//
// Stage 1 denormalizes (when the biased exponent is <= 0) and rounds the
// significand. Stage 2 classifies special cases, detects overflow and packs
// the 32-bit result together with the {NV,DZ,OF,UF,NX} exception flags.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     input handshake
//   in_sig                  sign
//   in_expo [9:0]           biased exponent, two's complement (-64..511)
//   in_mant [24:0]          significand, [23] hidden bit, [24] unused (zero)
//   in_grs  [2:0]           guard, round, sticky
//   in_rm   [2:0]           0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RNE
//   in_snan..in_zero        special-case markers
//   out_valid / out_ready   output handshake
//   out_result [31:0]       packed single
//   out_flags  [4:0]        {NV,DZ,OF,UF,NX}
module fp_rnd_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sig,
  input  logic [9:0]  in_expo,
  input  logic [24:0] in_mant,
  input  logic [2:0]  in_grs,
  input  logic [2:0]  in_rm,
  input  logic        in_snan,
  input  logic        in_qnan,
  input  logic        in_dbz,
  input  logic        in_infs,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags
);

  typedef enum logic [2:0] {
    RmRne = 3'd0,
    RmRtz = 3'd1,
    RmRdn = 3'd2,
    RmRup = 3'd3,
    RmRmm = 3'd4
  } rm_e;

  // ---------------------------------------------------------------------------
  // Stage 1: denormalize and round (combinational, registered into r1_*)
  // ---------------------------------------------------------------------------
  logic        w_denorm;
  logic [10:0] w_shamt_full;
  logic [4:0]  w_shamt;
  logic [26:0] w_pre;
  logic [26:0] w_shifted;
  logic        w_lost;
  logic [23:0] w_m;
  logic        w_g, w_r, w_s;
  logic        w_tiny;
  logic        w_inexact;
  logic        w_inc;
  logic [24:0] w_sum;
  logic [9:0]  w_exp;
  logic [22:0] w_frac;
  rm_e         w_rm;
  logic        w_unused;

  assign w_unused = in_mant[24];

  always_comb begin
    w_pre        = {in_mant[23:0], in_grs};
    w_denorm     = in_expo[9] | (in_expo == 10'd0);
    // 1 - expo, sign-extended so that expo = -64 gives 65
    w_shamt_full = 11'd1 - {in_expo[9], in_expo};
    w_shamt      = (w_shamt_full > 11'd26) ? 5'd26 : w_shamt_full[4:0];
    w_shifted    = w_pre >> w_shamt;
    // Bits that fall off the bottom fold into sticky
    w_lost       = |(w_pre & ~(27'h7FF_FFFF << w_shamt));

    if (w_denorm) begin
      {w_m, w_g, w_r, w_s} = {w_shifted[26:1], w_shifted[0] | w_lost};
    end else begin
      {w_m, w_g, w_r, w_s} = w_pre;
    end

    w_tiny    = w_denorm & (|{w_m, w_g, w_r, w_s});
    w_inexact = w_g | w_r | w_s;

    case (in_rm)
      3'd1:    w_rm = RmRtz;
      3'd2:    w_rm = RmRdn;
      3'd3:    w_rm = RmRup;
      3'd4:    w_rm = RmRmm;
      default: w_rm = RmRne;
    endcase

    case (w_rm)
      RmRtz:   w_inc = 1'b0;
      RmRdn:   w_inc = in_sig & w_inexact;
      RmRup:   w_inc = ~in_sig & w_inexact;
      RmRmm:   w_inc = w_g;
      default: w_inc = w_g & (w_m[0] | w_r | w_s);
    endcase

    w_sum  = {1'b0, w_m} + {24'd0, w_inc};
    w_exp  = w_denorm ? 10'd0 : in_expo;
    w_frac = w_sum[22:0];
    if (w_sum[24]) begin
      // Carry out of the significand: renormalize
      w_exp  = w_exp + 10'd1;
      w_frac = w_sum[23:1];
    end else if (w_denorm && w_sum[23]) begin
      // Subnormal rounded up into the smallest normal
      w_exp = 10'd1;
    end
  end

  logic        r1_valid;
  logic        r1_sig;
  logic [9:0]  r1_exp;
  logic [22:0] r1_frac;
  logic        r1_inexact;
  logic        r1_tiny;
  rm_e         r1_rm;
  logic        r1_snan, r1_qnan, r1_dbz, r1_infs, r1_zero;

  // ---------------------------------------------------------------------------
  // Stage 2: classify and pack (combinational, registered into outputs)
  // ---------------------------------------------------------------------------
  logic        w_to_max;
  logic [31:0] w_res;
  logic [4:0]  w_flg;

  always_comb begin
    // Overflow saturates to the largest finite value when rounding toward zero
    w_to_max = (r1_rm == RmRtz) | ((r1_rm == RmRdn) & ~r1_sig) |
               ((r1_rm == RmRup) & r1_sig);
    w_res    = {r1_sig, r1_exp[7:0], r1_frac};
    w_flg    = {3'b000, r1_tiny & r1_inexact, r1_inexact};
    if (r1_snan) begin
      w_res = 32'h7FC0_0000;
      w_flg = 5'b10000;
    end else if (r1_qnan) begin
      w_res = 32'h7FC0_0000;
      w_flg = 5'b00000;
    end else if (r1_dbz) begin
      w_res = {r1_sig, 8'hFF, 23'd0};
      w_flg = 5'b01000;
    end else if (r1_infs) begin
      w_res = {r1_sig, 8'hFF, 23'd0};
      w_flg = 5'b00000;
    end else if (r1_zero) begin
      w_res = {r1_sig, 31'd0};
      w_flg = 5'b00000;
    end else if (r1_exp >= 10'd255) begin
      w_res = w_to_max ? {r1_sig, 31'h7F7F_FFFF} : {r1_sig, 8'hFF, 23'd0};
      w_flg = 5'b00101;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic r2_valid;
  logic w_adv1, w_adv2;

  assign w_adv2    = ~r2_valid | out_ready;
  assign w_adv1    = ~r1_valid | w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r2_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r1_valid   <= 1'b0;
      r1_sig     <= 1'b0;
      r1_exp     <= 10'd0;
      r1_frac    <= 23'd0;
      r1_inexact <= 1'b0;
      r1_tiny    <= 1'b0;
      r1_rm      <= RmRne;
      r1_snan    <= 1'b0;
      r1_qnan    <= 1'b0;
      r1_dbz     <= 1'b0;
      r1_infs    <= 1'b0;
      r1_zero    <= 1'b0;
      r2_valid   <= 1'b0;
      out_result <= 32'd0;
      out_flags  <= 5'd0;
    end else begin
      if (w_adv1) begin
        r1_valid <= in_valid;
        if (in_valid) begin
          r1_sig     <= in_sig;
          r1_exp     <= w_exp;
          r1_frac    <= w_frac;
          r1_inexact <= w_inexact;
          r1_tiny    <= w_tiny;
          r1_rm      <= w_rm;
          r1_snan    <= in_snan;
          r1_qnan    <= in_qnan;
          r1_dbz     <= in_dbz;
          r1_infs    <= in_infs;
          r1_zero    <= in_zero;
        end
      end
      if (w_adv2) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          out_result <= w_res;
          out_flags  <= w_flg;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Self-checking bench for fp_rnd_pipe: expected results come from a constant
// vector table, are queued on accept and compared as results leave the DUT.
module tb_fp_rnd_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sig;
  logic [9:0]  in_expo;
  logic [24:0] in_mant;
  logic [2:0]  in_grs;
  logic [2:0]  in_rm;
  logic        in_snan, in_qnan, in_dbz, in_infs, in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  fp_rnd_pipe u_dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sig     (in_sig),
    .in_expo    (in_expo),
    .in_mant    (in_mant),
    .in_grs     (in_grs),
    .in_rm      (in_rm),
    .in_snan    (in_snan),
    .in_qnan    (in_qnan),
    .in_dbz     (in_dbz),
    .in_infs    (in_infs),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic        sig;
    logic [9:0]  expo;
    logic [24:0] mant;
    logic [2:0]  grs;
    logic [2:0]  rm;
    logic [4:0]  spc;   // {snan,qnan,dbz,infs,zero}
    logic [31:0] res;
    logic [4:0]  flg;   // {NV,DZ,OF,UF,NX}
  } vec_t;

  vec_t        vecs[$];
  logic [36:0] sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add(input logic sig, input logic [9:0] expo, input logic [24:0] mant,
                     input logic [2:0] grs, input logic [2:0] rm, input logic [4:0] spc,
                     input logic [31:0] res, input logic [4:0] flg);
    vec_t v;
    v = '{sig: sig, expo: expo, mant: mant, grs: grs, rm: rm, spc: spc, res: res, flg: flg};
    vecs.push_back(v);
  endtask

  // Drive one bundle and hold it until accepted (bounded).
  task automatic send(input int idx, input int budget, output int tries, output int acc_cyc);
    vec_t v;
    logic acc;
    v        = vecs[idx];
    in_sig   = v.sig;
    in_expo  = v.expo;
    in_mant  = v.mant;
    in_grs   = v.grs;
    in_rm    = v.rm;
    {in_snan, in_qnan, in_dbz, in_infs, in_zero} = v.spc;
    in_valid = 1'b1;
    acc      = 1'b0;
    tries    = 0;
    acc_cyc  = -1;
    while (!acc && tries < budget) begin
      @(negedge clock);
      acc     = in_ready;
      acc_cyc = cyc;
      @(posedge clock);
      #1;
      tries++;
    end
    if (acc) sb.push_back({v.res, v.flg});
    else check_eq("accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (sb.size() == 0) break;
      @(posedge clock);
      #1;
    end
    check_eq(tag, sb.size(), 0);
  endtask

  // Output monitor: occupancy-based ready check, stall stability, scoreboard.
  int          occ;
  logic        stall_prev = 1'b0;
  logic        saw_full   = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_flg;
  logic [36:0] exp_e;

  always @(negedge clock) begin
    if (mon_en) begin
      occ = sb.size();
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, (occ < 2) || out_ready});
      if (!in_ready) saw_full = 1'b1;
      if (occ == 0) check_eq("idle_valid", {63'd0, out_valid}, 64'd0);
      if (stall_prev) begin
        check_eq("stall_res", out_result, held_res);
        check_eq("stall_flg", out_flags, held_flg);
      end
      stall_prev = out_valid & ~out_ready & ~reset;
      held_res   = out_result;
      held_flg   = out_flags;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_output", {63'd0, out_valid}, 64'd0);
        end else begin
          exp_e = sb.pop_front();
          check_eq("result", out_result, exp_e[36:5]);
          check_eq("flags", out_flags, exp_e[4:0]);
        end
      end
    end
  end

  int tries, acc_cyc, lat;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sig    = 1'b0;
    in_expo   = 10'd0;
    in_mant   = 25'd0;
    in_grs    = 3'd0;
    in_rm     = 3'd0;
    {in_snan, in_qnan, in_dbz, in_infs, in_zero} = 5'd0;
    out_ready = 1'b1;

    //  sig expo      mant         grs     rm    spc       result        flags
    add(0, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b00000, 32'h3F80_0000, 5'b00000);
    add(0, 10'd157, 25'h0FFFFFF, 3'b111, 3'd0, 5'b00000, 32'h4F00_0000, 5'b00001);
    add(0, 10'd157, 25'h0FFFFFF, 3'b111, 3'd1, 5'b00000, 32'h4EFF_FFFF, 5'b00001);
    add(1, 10'd255, 25'h0800000, 3'b000, 3'd1, 5'b00000, 32'hFF7F_FFFF, 5'b00101);
    add(1, 10'd255, 25'h0800000, 3'b000, 3'd0, 5'b00000, 32'hFF80_0000, 5'b00101);
    add(0, 10'd0,   25'h0800001, 3'b000, 3'd0, 5'b00000, 32'h0040_0000, 5'b00011);
    add(0, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b10000, 32'h7FC0_0000, 5'b10000);
    add(1, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b00100, 32'hFF80_0000, 5'b01000);
    add(0, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b01000, 32'h7FC0_0000, 5'b00000);
    add(0, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b00010, 32'h7F80_0000, 5'b00000);
    add(1, 10'd127, 25'h0800000, 3'b111, 3'd0, 5'b00001, 32'h8000_0000, 5'b00000);
    add(0, 10'd127, 25'h0800000, 3'b100, 3'd4, 5'b00000, 32'h3F80_0001, 5'b00001);
    add(0, 10'd127, 25'h0800000, 3'b100, 3'd0, 5'b00000, 32'h3F80_0000, 5'b00001);
    add(1, 10'd127, 25'h0800000, 3'b001, 3'd2, 5'b00000, 32'hBF80_0001, 5'b00001);
    add(0, 10'd255, 25'h0800000, 3'b000, 3'd3, 5'b00000, 32'h7F80_0000, 5'b00101);
    add(0, 10'd255, 25'h0800000, 3'b000, 3'd2, 5'b00000, 32'h7F7F_FFFF, 5'b00101);
    add(0, 10'h3FE, 25'h0800000, 3'b000, 3'd1, 5'b00000, 32'h0010_0000, 5'b00000);
    add(0, 10'd0,   25'h0FFFFFF, 3'b000, 3'd0, 5'b00000, 32'h0080_0000, 5'b00011);
    add(0, 10'h3C0, 25'h0800000, 3'b000, 3'd3, 5'b00000, 32'h0000_0001, 5'b00011);
    add(0, 10'd157, 25'h0FFFFFF, 3'b111, 3'd7, 5'b00000, 32'h4F00_0000, 5'b00001);
    add(0, 10'd254, 25'h0FFFFFF, 3'b111, 3'd0, 5'b00000, 32'h7F80_0000, 5'b00101);
    add(0, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b10100, 32'h7FC0_0000, 5'b10000);

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_result", out_result, 64'd0);
    check_eq("rst_out_flags", out_flags, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    mon_en = 1'b1;
    @(posedge clock);
    #1;

    // Latency from the accepting cycle to out_valid
    send(0, 10, tries, acc_cyc);
    in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (out_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    check_eq("latency", lat, 2);
    drain("drain_latency", 20);

    // Full-rate stream, every bundle accepted on first try
    for (int i = 0; i < vecs.size(); i++) begin
      send(i, 10, tries, acc_cyc);
      check_eq("throughput", tries, 1);
    end
    in_valid = 1'b0;
    drain("drain_stream", 50);

    // Eight bundles back-to-back with a 3-cycle consumer stall mid-stream
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, 20, tries, acc_cyc);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall", 50);
    check_eq("stall_seen", {63'd0, saw_full}, 64'd1);

    // Reset with both stages full
    out_ready = 1'b0;
    send(1, 10, tries, acc_cyc);
    send(2, 10, tries, acc_cyc);
    in_valid = 1'b0;
    @(negedge clock);
    check_eq("full_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    check_eq("rst2_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst2_out_result", out_result, 64'd0);
    check_eq("rst2_out_flags", out_flags, 64'd0);
    check_eq("rst2_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Pipeline still works after the flush
    send(5, 10, tries, acc_cyc);
    in_valid = 1'b0;
    drain("drain_post_reset", 20);

    repeat (2) @(posedge clock);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
